prefetch_unit: RTL and testbench
================================

Name: prefetch_unit

Overview:
- Parametrised next-generation instruction fetch stage.
- Decouples PC generation from decode with a DEPTH-entry prefetch queue and a valid/ready request/response interface to instruction memory, so memory may have variable latency.
- Supports start-address load, branch redirect with queue flush and discard of in-flight responses, and decode back-pressure.
- Sits between the instruction memory port and the decode stage.

Parameters:
- WORD_SIZE, 32, instruction width in bits.
- ADDR_W, 32, PC and address width in bits.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- INSTR_BYTES, 4, PC increment per fetched instruction.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  load start_address and begin fetching.
- start_address  input  ADDR_W  first fetch address.
- redirect  input  1  branch taken; flush and refetch.
- redirect_pc  input  ADDR_W  branch target.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  ADDR_W  fetch address.
- imem_rsp_valid  input  1  in-order response valid.
- imem_rsp_data  input  WORD_SIZE  fetched instruction.
- out_valid  output  1  queue head valid to decode.
- out_ready  input  1  decode accepts head.
- out_instr  output  WORD_SIZE  head instruction.
- out_pc  output  ADDR_W  PC of head instruction.
- busy  output  1  state is RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: state IDLE, pc 0, rsp_pc 0, outstanding 0, drop_cnt 0, queue empty. All outputs 0.
- States are IDLE and RUN.
  - IDLE → RUN on start; pc and rsp_pc load start_address.
  - No exit from RUN except reset.
  - start while in RUN acts as a redirect to start_address.
  - start takes priority over redirect.
- Request issue:
  - imem_req_valid = RUN && !start && !redirect && (occupancy + outstanding) < DEPTH.
  - imem_req_addr = pc.
  - On handshake (req_valid && req_ready): pc ← pc + INSTR_BYTES, modulo 2^ADDR_W (wraps silently). outstanding increments.
  - imem_req_valid never depends combinationally on imem_req_ready.
- Response handling:
  - Memory returns responses in order, at least one cycle after acceptance.
  - A response with outstanding == 0 is ignored.
  - Each accepted response decrements outstanding.
  - If drop_cnt > 0: the data is discarded and drop_cnt decrements.
  - Otherwise: push {rsp_pc, imem_rsp_data} into the queue, then rsp_pc ← rsp_pc + INSTR_BYTES.
  - The credit rule guarantees a push never overflows the queue.
- Output side:
  - out_valid = queue not empty. out_instr and out_pc come from the head.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle keep occupancy unchanged, including when the queue is full.
  - Queue is registered: a pushed entry is visible on out_valid the next cycle.
- Redirect, or start while in RUN (cycle T):
  - Queue cleared at the end of T; any pop in T is ignored; out_valid is 0 in T+1.
  - pc and rsp_pc ← target.
  - A response arriving in T is discarded.
  - drop_cnt ← outstanding after T's response decrement.
  - No request is issued in T. The first request to the target is issued in T+1.
  - A redirect in consecutive cycles: the last one wins, and drop_cnt accumulates correctly.
- Latency, with 1-cycle memory and out_ready held high:
  - start in cycle 0.
  - Request issued in cycle 1.
  - Response arrives in cycle 2.
  - out_valid asserted in cycle 3.
  - Sustained throughput thereafter: one instruction per cycle.
- Asynchronous reset mid-operation:
  - Returns to reset values immediately.
  - In-flight memory responses after reset release are ignored (outstanding is 0).
- Width rules:
  - Occupancy, outstanding and drop_cnt are $clog2(DEPTH+1) bits.
  - All address arithmetic is ADDR_W bits, carry discarded.

Decomposition:
- Shared constants header: default WORD_SIZE, ADDR_W, INSTR_BYTES, and the state encodings (IDLE=0, RUN=1).
- One sub-module, prefetch_fifo: a synchronous DEPTH × (ADDR_W+WORD_SIZE) FIFO.
  - Inputs: push, pop, flush. Outputs: full, empty, occupancy.
  - Flush has priority over push and pop.
  - Same clk and rst as the parent.
- The top level holds the FSM, PC, credit counters and drop logic.

Test Plan:
1. Reset, then start with start_address=0x100, 1-cycle memory, out_ready=1 → req addrs 0x100, 0x104, 0x108…; first out_valid in cycle 3 with out_pc=0x100; one instruction per cycle after.
2. out_ready=0 with memory always ready → exactly DEPTH=4 requests issued; queue fills; imem_req_valid stays low; raising out_ready drains in order 0x100–0x10C, then fetching resumes.
3. 3-cycle memory latency, redirect to 0x200 with 2 requests outstanding → both stale responses discarded (drop_cnt 2→0); next out_pc=0x200; no stale PC ever appears on out.
4. Redirect and pop in the same cycle with the queue full → out_valid=0 the next cycle; occupancy 0; first request to redirect_pc issued next cycle.
5. start_address=0xFFFFFFFC → out_pc sequence 0xFFFFFFFC, 0x00000000, 0x00000004 (wrap-around).
6. Reset asserted mid-stream with 2 requests outstanding → outputs 0 immediately; responses after release ignored; state IDLE until the next start.

Source files
------------

// File: rtl/prefetch_unit_pkg.sv
// Shared defaults and state encoding for the instruction prefetch stage.
package prefetch_unit_pkg;

  localparam int unsigned WORD_SIZE_DEF   = 32;
  localparam int unsigned ADDR_W_DEF      = 32;
  localparam int unsigned DEPTH_DEF       = 4;
  localparam int unsigned INSTR_BYTES_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous prefetch queue; flush overrides push and pop, push into a full
// queue is accepted only when a pop frees the head in the same cycle.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign occupancy = count_q;
  assign rdata     = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && (!full || do_pop) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction fetch stage: issues credited requests to instruction memory and
// queues in-order responses for decode, with redirect flush and stale-drop.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = WORD_SIZE_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_address,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ADDR_W-1:0]    imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [WORD_SIZE-1:0] imem_rsp_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_instr,
  output logic [ADDR_W-1:0]    out_pc,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = ADDR_W + WORD_SIZE;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic [CNT_W-1:0]    occupancy;
  logic [CNT_W:0]      credits_used;
  logic [CNT_W-1:0]    out_after_rsp;
  logic [ADDR_W-1:0]   target;
  logic                kill;
  logic                req_fire;
  logic                rsp_take;
  logic                fifo_push, fifo_pop, fifo_flush;
  logic                fifo_full, fifo_empty;
  logic [ENT_W-1:0]    fifo_rdata;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .wdata     ({rsp_pc_q, imem_rsp_data}),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    rsp_pc_d       = rsp_pc_q;
    outstanding_d  = outstanding_q;
    drop_d         = drop_q;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    imem_req_valid = 1'b0;
    kill           = 1'b0;
    target         = start ? start_address : redirect_pc;
    credits_used   = (CNT_W+1)'(occupancy) + (CNT_W+1)'(outstanding_q);
    rsp_take       = imem_rsp_valid && (outstanding_q != '0);
    out_after_rsp  = outstanding_q - CNT_W'(rsp_take);

    if (state_q == RUN) begin
      kill           = start || redirect;
      imem_req_valid = !kill && (credits_used < (CNT_W+1)'(DEPTH));
    end

    req_fire      = imem_req_valid && imem_req_ready;
    outstanding_d = out_after_rsp + CNT_W'(req_fire);

    // Every response still in flight after a redirect belongs to the old path.
    if (kill) begin
      fifo_flush = 1'b1;
      pc_d       = target;
      rsp_pc_d   = target;
      drop_d     = out_after_rsp;
    end else begin
      fifo_pop = !fifo_empty && out_ready;
      if (rsp_take) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          fifo_push = !fifo_full || fifo_pop;
          rsp_pc_d  = rsp_pc_q + ADDR_W'(INSTR_BYTES);
        end
      end
      if (req_fire) pc_d = pc_q + ADDR_W'(INSTR_BYTES);
    end

    if (state_q == IDLE && start) begin
      state_d  = RUN;
      pc_d     = start_address;
      rsp_pc_d = start_address;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      rsp_pc_q      <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign busy          = (state_q == RUN);
  assign out_valid     = !fifo_empty;
  assign out_pc        = fifo_empty ? '0 : fifo_rdata[ENT_W-1 -: ADDR_W];
  assign out_instr     = fifo_empty ? '0 : fifo_rdata[WORD_SIZE-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a queue-based reference model and memory.
module tb_prefetch_unit;

  localparam int unsigned WS    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, redirect, imem_req_ready, imem_rsp_valid, out_ready;
  logic [AW-1:0] start_address, redirect_pc;
  logic          imem_req_valid, out_valid, busy;
  logic [AW-1:0] imem_req_addr, out_pc;
  logic [WS-1:0] imem_rsp_data, out_instr;

  always #5 clk = ~clk;

  prefetch_unit #(.WORD_SIZE(WS), .ADDR_W(AW), .DEPTH(DEPTH), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_address(start_address),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .busy(busy)
  );

  typedef struct { logic [31:0] addr; int due; } mem_t;
  typedef struct { logic [31:0] addr; bit stale; } inf_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  mem_t        mem_q[$];
  inf_t        inf_q[$];
  ent_t        fifo_m[$];
  logic [31:0] popped[$];
  logic [31:0] reqs[$];
  bit          running;
  logic [31:0] m_pc;
  int          cyc, lat, first_ov, t0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] mdata(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: memory drives its response, outputs are compared, model advances.
  task automatic cycle();
    logic        e_rv, e_ov, kill;
    logic [31:0] e_pc, e_in, tgt;
    inf_t        e;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(mem_q[0].addr);
      mem_q.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    if (!rst) begin
      running = 0; m_pc = '0; fifo_m.delete(); inf_q.delete();
    end
    #1;
    e_rv = running && !start && !redirect && (fifo_m.size() + inf_q.size() < DEPTH);
    e_ov = fifo_m.size() > 0;
    e_pc = e_ov ? fifo_m[0].pc : 32'h0;
    e_in = e_ov ? fifo_m[0].instr : 32'h0;
    check("busy", busy, running);
    check("req_valid", imem_req_valid, e_rv);
    check("req_addr", imem_req_addr, m_pc);
    check("out_valid", out_valid, e_ov);
    check("out_pc", out_pc, e_pc);
    check("out_instr", out_instr, e_in);
    if (rst) begin
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (imem_req_valid && imem_req_ready) begin
        reqs.push_back(imem_req_addr);
        mem_q.push_back('{imem_req_addr, cyc + lat});
      end
      if (out_valid && out_ready && !(start || redirect)) popped.push_back(out_pc);
      kill = running && (start || redirect);
      tgt  = start ? start_address : redirect_pc;
      if (!kill && e_ov && out_ready) fifo_m.delete(0);
      if (imem_rsp_valid && inf_q.size() > 0) begin
        e = inf_q[0];
        inf_q.delete(0);
        if (!kill && !e.stale) fifo_m.push_back('{e.addr, imem_rsp_data});
      end
      if (e_rv && imem_req_ready) begin
        inf_q.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (kill) begin
        fifo_m.delete();
        foreach (inf_q[i]) inf_q[i].stale = 1'b1;
        m_pc = tgt;
      end
      if (!running && start) begin
        running = 1; m_pc = start_address;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 0; redirect = 0;
    mem_q.delete();
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    reqs.delete(); popped.delete(); first_ov = -1;
  endtask

  task automatic go(logic [31:0] a);
    start = 1'b1; start_address = a; t0 = cyc;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 0; redirect = 0; start_address = '0; redirect_pc = '0;
    imem_req_ready = 1; imem_rsp_valid = 0; imem_rsp_data = '0; out_ready = 1;
    cyc = 0; lat = 1; first_ov = -1; running = 0; m_pc = '0;
    @(negedge clk);
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);

    // 1: streaming from 0x100, single-cycle memory
    go(32'h100);
    repeat (12) cycle();
    check("t1_first_valid_latency", 64'(first_ov - t0), 64'd3);
    check("t1_pop0", popped[0], 32'h100);
    check("t1_pop1", popped[1], 32'h104);
    check("t1_pop3", popped[3], 32'h10C);
    check("t1_req2", reqs[2], 32'h108);
    check("t1_throughput", popped.size(), 10);

    // 2: decode stalled, queue fills, then drains in order
    do_reset();
    out_ready = 0;
    go(32'h100);
    repeat (10) cycle();
    check("t2_req_count", reqs.size(), 4);
    check("t2_req_valid_low", imem_req_valid, 1'b0);
    out_ready = 1;
    repeat (8) cycle();
    check("t2_drain0", popped[0], 32'h100);
    check("t2_drain3", popped[3], 32'h10C);
    check("t2_resume", reqs[4], 32'h110);

    // 3: three-cycle memory, redirect with two requests in flight
    do_reset();
    lat = 3;
    go(32'h100);
    cycle(); cycle();
    redirect = 1; redirect_pc = 32'h200;
    cycle();
    redirect = 0;
    repeat (12) cycle();
    check("t3_req_after_redirect", reqs[2], 32'h200);
    check("t3_first_pc", popped[0], 32'h200);
    check("t3_second_pc", popped[1], 32'h204);
    foreach (popped[i]) check("t3_no_stale", popped[i] >= 32'h200, 1'b1);

    // 4: redirect and pop in the same cycle with a full queue
    do_reset();
    lat = 1; out_ready = 0;
    go(32'h100);
    repeat (8) cycle();
    check("t4_full_no_req", imem_req_valid, 1'b0);
    out_ready = 1; redirect = 1; redirect_pc = 32'h300;
    cycle();
    redirect = 0;
    #1;
    check("t4_out_valid_after", out_valid, 1'b0);
    check("t4_req_valid_after", imem_req_valid, 1'b1);
    check("t4_req_addr_after", imem_req_addr, 32'h300);
    check("t4_killed_pop", popped.size(), 0);
    repeat (6) cycle();
    check("t4_first_pc", popped[0], 32'h300);

    // 5: address wrap-around
    do_reset();
    go(32'hFFFF_FFFC);
    repeat (8) cycle();
    check("t5_count", popped.size() >= 3, 1'b1);
    check("t5_pc0", popped[0], 32'hFFFF_FFFC);
    check("t5_pc1", popped[1], 32'h0000_0000);
    check("t5_pc2", popped[2], 32'h0000_0004);

    // 6: asynchronous reset with requests in flight
    do_reset();
    lat = 3;
    go(32'h100);
    cycle(); cycle();
    rst = 1'b0;
    #1;
    check("t6_busy_now", busy, 1'b0);
    check("t6_req_valid_now", imem_req_valid, 1'b0);
    check("t6_req_addr_now", imem_req_addr, 32'h0);
    check("t6_out_valid_now", out_valid, 1'b0);
    cycle();
    rst = 1'b1;
    popped.delete();
    repeat (6) cycle();
    check("t6_idle", busy, 1'b0);
    check("t6_nothing_popped", popped.size(), 0);
    lat = 1;
    go(32'h400);
    repeat (6) cycle();
    check("t6_restart_pc", popped[0], 32'h400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
